// File: rtl/gs_update_pe.sv
// gs_update_pe: 3-stage Gauss-Seidel update, x_new = (b + 13*s1 - 6*s2 + s3) / 20 floored and saturated.
module gs_update_pe #(
  parameter int BIT_WIDTH = 32,
  parameter int FRAC      = 16,
  parameter int B_WIDTH   = 16,
  parameter int TOL       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic [3:0]           i_idx,
  input  logic [B_WIDTH-1:0]   i_b,
  input  logic [BIT_WIDTH-1:0] i_xc,
  input  logic [BIT_WIDTH-1:0] i_xm1,
  input  logic [BIT_WIDTH-1:0] i_xp1,
  input  logic [BIT_WIDTH-1:0] i_xm2,
  input  logic [BIT_WIDTH-1:0] i_xp2,
  input  logic [BIT_WIDTH-1:0] i_xm3,
  input  logic [BIT_WIDTH-1:0] i_xp3,
  output logic                 o_valid,
  output logic [3:0]           o_idx,
  output logic [BIT_WIDTH-1:0] o_x,
  output logic                 o_conv
);
  localparam int SW = BIT_WIDTH + 1;
  localparam int AW = ((BIT_WIDTH > B_WIDTH + FRAC) ? BIT_WIDTH : B_WIDTH + FRAC) + 6;
  localparam logic signed [AW-1:0] DIV  = AW'(20);
  localparam logic signed [AW-1:0] XMAX = AW'({1'b0, {(BIT_WIDTH-1){1'b1}}});
  localparam logic signed [AW-1:0] XMIN = AW'($signed({1'b1, {(BIT_WIDTH-1){1'b0}}}));
  localparam logic signed [SW-1:0] TOLV = SW'(TOL);

  // the upstream register is circular, so taps past either end hold wrapped data
  logic signed [SW-1:0] m1, m2, m3, p1, p2, p3;
  assign m1 = (i_idx < 4'd1)  ? '0 : SW'($signed(i_xm1));
  assign m2 = (i_idx < 4'd2)  ? '0 : SW'($signed(i_xm2));
  assign m3 = (i_idx < 4'd3)  ? '0 : SW'($signed(i_xm3));
  assign p1 = (i_idx > 4'd14) ? '0 : SW'($signed(i_xp1));
  assign p2 = (i_idx > 4'd13) ? '0 : SW'($signed(i_xp2));
  assign p3 = (i_idx > 4'd12) ? '0 : SW'($signed(i_xp3));

  logic                        v1;
  logic [3:0]                  idx1;
  logic signed [B_WIDTH-1:0]   b1;
  logic signed [BIT_WIDTH-1:0] xc1;
  logic signed [SW-1:0]        s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      idx1 <= '0;
      b1   <= '0;
      xc1  <= '0;
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
    end else begin
      v1   <= i_valid;
      idx1 <= i_idx;
      b1   <= $signed(i_b);
      xc1  <= $signed(i_xc);
      s1   <= m1 + p1;
      s2   <= m2 + p2;
      s3   <= m3 + p3;
    end
  end

  logic signed [AW-1:0] e1, e2, e3, bx, acc_d;
  assign e1    = AW'(s1);
  assign e2    = AW'(s2);
  assign e3    = AW'(s3);
  assign bx    = AW'(b1) <<< FRAC;
  assign acc_d = bx + (e1 <<< 3) + (e1 <<< 2) + e1 - (e2 <<< 2) - (e2 <<< 1) + e3;

  logic                        v2;
  logic [3:0]                  idx2;
  logic signed [BIT_WIDTH-1:0] xc2;
  logic signed [AW-1:0]        acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      idx2 <= '0;
      xc2  <= '0;
      acc  <= '0;
    end else begin
      v2   <= v1;
      idx2 <= idx1;
      xc2  <= xc1;
      acc  <= acc_d;
    end
  end

  // signed '/' truncates toward zero; step down one when a negative quotient left a remainder
  logic signed [AW-1:0]        q_t, r, q;
  logic                        fix, sat_hi, sat_lo;
  logic signed [BIT_WIDTH-1:0] x_sat;
  logic signed [SW-1:0]        diff;
  logic                        conv;
  assign q_t    = acc / DIV;
  assign r      = acc % DIV;
  assign fix    = acc[AW-1] && (r != '0);
  assign q      = q_t - {{(AW-1){1'b0}}, fix};
  assign sat_hi = q > XMAX;
  assign sat_lo = q < XMIN;
  assign x_sat  = sat_hi ? XMAX[BIT_WIDTH-1:0] : sat_lo ? XMIN[BIT_WIDTH-1:0] : q[BIT_WIDTH-1:0];
  assign diff   = SW'(x_sat) - SW'(xc2);
  assign conv   = (diff <= TOLV) && (diff >= -TOLV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_idx   <= '0;
      o_x     <= '0;
      o_conv  <= 1'b0;
    end else begin
      o_valid <= v2;
      o_idx   <= idx2;
      o_x     <= x_sat;
      o_conv  <= conv;
    end
  end
endmodule
